sixty_four_bit_subtractor_seq: RTL and testbench

Multi-cycle 64-bit subtractor that computes diff = a - b - borrow_in, processing one SLICE_W-bit slice per clock. Borrow ripples between slices through a borrow register. Uses a start/busy/done handshake. It is the inverse-operation companion to the combinational 64-bit adder, and shares that adder's operand widths and carry/borrow semantics.

---
 rtl/sixty_four_bit_subtractor_seq_pkg.sv | 13 +
 rtl/sixty_four_bit_subtractor_seq_if.sv | 33 +++
 rtl/sixty_four_bit_subtractor_seq_slice_subtractor.sv | 35 +++
 rtl/sixty_four_bit_subtractor_seq.sv | 112 +++++++++++
 tb/tb_sixty_four_bit_subtractor_seq.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/sixty_four_bit_subtractor_seq_pkg.sv
// rtl/sixty_four_bit_subtractor_seq_pkg.sv - shared widths, counter width and FSM encoding (package sub_pkg)
package sub_pkg;
    localparam int DATA_W     = 64;
    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int CNT_W      = $clog2(NUM_SLICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sixty_four_bit_subtractor_seq_if.sv
// rtl/sixty_four_bit_subtractor_seq_if.sv - start/busy/done operand and result bundle; op exists only with ADD_SUB_MODE_EN
interface sixty_four_bit_subtractor_seq_if;
    import sub_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              borrow_in;
`ifdef ADD_SUB_MODE_EN
    logic              op;
`endif
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] diff;
    logic              borrow_out;
    logic              overflow;

    modport master (
        output start, a, b, borrow_in,
`ifdef ADD_SUB_MODE_EN
        output op,
`endif
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b, borrow_in,
`ifdef ADD_SUB_MODE_EN
        input  op,
`endif
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/sixty_four_bit_subtractor_seq_slice_subtractor.sv
// rtl/sixty_four_bit_subtractor_seq_slice_subtractor.sv - combinational SLICE_W-bit subtract with borrow (add mode under ADD_SUB_MODE_EN)
module slice_subtractor
    import sub_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               bin,
`ifdef ADD_SUB_MODE_EN
    input  logic               op,
`endif
    output logic [SLICE_W-1:0] d,
    output logic               bout
);
    logic [SLICE_W:0] sum;

    // Subtraction is x + ~y + ~bin; the carry out is the inverse of the borrow.
    always_comb begin
        sum  = '0;
        bout = 1'b0;
`ifdef ADD_SUB_MODE_EN
        if (op) begin
            sum  = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, bin};
            bout = sum[SLICE_W];
        end else begin
            sum  = {1'b0, x} + {1'b0, ~y} + {{SLICE_W{1'b0}}, ~bin};
            bout = ~sum[SLICE_W];
        end
`else
        sum  = {1'b0, x} + {1'b0, ~y} + {{SLICE_W{1'b0}}, ~bin};
        bout = ~sum[SLICE_W];
`endif
    end

    assign d = sum[SLICE_W-1:0];
endmodule

// File: rtl/sixty_four_bit_subtractor_seq.sv
// rtl/sixty_four_bit_subtractor_seq.sv - slice-serial 64-bit subtractor, one slice per clock; ADD_SUB_MODE_EN adds add mode
module sixty_four_bit_subtractor_seq
    import sub_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    sixty_four_bit_subtractor_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  a_reg;
    logic [DATA_W-1:0]  b_reg;
    logic               brw_reg;
    logic [DATA_W-1:0]  diff_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               borrow_out_reg;
    logic               overflow_reg;
`ifdef ADD_SUB_MODE_EN
    logic               op_reg;
`endif

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] d_sl;
    logic               brw_nxt;
    logic               ovf_nxt;

    assign a_sl = a_reg[cnt*SLICE_W +: SLICE_W];
    assign b_sl = b_reg[cnt*SLICE_W +: SLICE_W];

    slice_subtractor u_slice (
        .x    (a_sl),
        .y    (b_sl),
        .bin  (brw_reg),
`ifdef ADD_SUB_MODE_EN
        .op   (op_reg),
`endif
        .d    (d_sl),
        .bout (brw_nxt)
    );

    // Only meaningful on the last slice, where d_sl carries the result sign bit.
    always_comb begin
        ovf_nxt = (a_reg[DATA_W-1] != b_reg[DATA_W-1]) && (d_sl[SLICE_W-1] != a_reg[DATA_W-1]);
`ifdef ADD_SUB_MODE_EN
        if (op_reg)
            ovf_nxt = (a_reg[DATA_W-1] == b_reg[DATA_W-1]) && (d_sl[SLICE_W-1] != a_reg[DATA_W-1]);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            brw_reg        <= 1'b0;
            diff_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
`ifdef ADD_SUB_MODE_EN
            op_reg         <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    diff_reg[cnt*SLICE_W +: SLICE_W] <= d_sl;
                    brw_reg <= brw_nxt;
                    if (cnt == LAST) begin
                        borrow_out_reg <= brw_nxt;
                        overflow_reg   <= ovf_nxt;
                        busy_reg       <= 1'b0;
                        done_reg       <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and DONE share the accept path so DONE can restart without a bubble.
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg    <= bus.a;
                        b_reg    <= bus.b;
                        brw_reg  <= bus.borrow_in;
`ifdef ADD_SUB_MODE_EN
                        op_reg   <= bus.op;
`endif
                        cnt      <= '0;
                        diff_reg <= '0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy_reg <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.diff       = diff_reg;
    assign bus.borrow_out = borrow_out_reg;
    assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_sixty_four_bit_subtractor_seq.sv
// tb/tb_sixty_four_bit_subtractor_seq.sv - scoreboard bench for sixty_four_bit_subtractor_seq
module tb_sixty_four_bit_subtractor_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] ed;
        logic        ebo;
        logic        eov;
        int          acc;
    } exp_t;

    exp_t q[$];

    sixty_four_bit_subtractor_seq_if bus ();

    sixty_four_bit_subtractor_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Caller is at a negedge; accept happens at the following posedge.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                            input logic [63:0] ed, input logic ebo, input logic eov, input bit push);
        exp_t e;
        bus.a = a;
        bus.b = b;
        bus.borrow_in = bin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e.a = a; e.b = b; e.bin = bin; e.ed = ed; e.ebo = ebo; e.eov = eov; e.acc = cyc;
        if (push) q.push_back(e);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_done: got timeout expected done within 20 cycles");
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (diff=%h)", bus.diff);
            end else begin
                exp_t e;
                logic [64:0] m;
                e = q.pop_front();
                m = {1'b0, e.a} - {1'b0, e.b} - 65'(e.bin);
                check("diff", bus.diff, e.ed);
                check("borrow_out", 64'(bus.borrow_out), 64'(e.ebo));
                check("overflow", 64'(bus.overflow), 64'(e.eov));
                check("latency_edges", 64'(cyc - e.acc), 64'd8);
                check("model_diff", bus.diff, m[63:0]);
                check("model_borrow", 64'(bus.borrow_out), 64'(m[64]));
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.borrow_in = 1'b0;
`ifdef ADD_SUB_MODE_EN
        bus.op = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_diff", bus.diff, 64'd0);
        check("rst_borrow_out", 64'(bus.borrow_out), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1);
        @(negedge clk);
        check("busy_in_run", 64'(bus.busy), 64'd1);
        wait_done();
        @(negedge clk);
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1);
        wait_done();
        @(negedge clk);
        start_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1);
        wait_done();
        @(negedge clk);
        start_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1);
        wait_done();
        @(negedge clk);
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1);
        wait_done();
        @(negedge clk);

        // start during RUN must be ignored; restart from DONE without a bubble
        start_op(64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 1);
        repeat (3) @(negedge clk);
        bus.a = '0;
        bus.b = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_ignored_start", 64'(bus.busy), 64'd1);
        wait_done();
        start_op(64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1);
        wait_done();
        @(negedge clk);

        // reset mid-RUN aborts with no done pulse
        start_op(64'd123, 64'd4, 1'b0, 64'd0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_diff", bus.diff, 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("pending_at_end", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
